id_receiver: RTL

ID_RECEIVER -- requirements
Module: id_receiver

---
 rtl/id_rx_pkg.sv | 32 +++
 rtl/uart_recv.sv | 152 +++++++++++++++
 rtl/id_receiver.sv | 70 +++++++
 3 files changed

// File: rtl/id_rx_pkg.sv
// Shared constants for the ID receiver: ID string, synchroniser depth, receiver states.
// UART_RX_PARITY_EN adds the PARITY state used by the 8E1 frame format.
`timescale 1ns/1ps
package id_rx_pkg;

    localparam int ID_LEN      = 10;
    localparam int SYNC_STAGES = 2;

    // "2024311668", first character received first
    localparam logic [7:0] ID_CHARS [ID_LEN] = '{
        8'h32, 8'h30, 8'h32, 8'h34, 8'h33,
        8'h31, 8'h31, 8'h36, 8'h36, 8'h38
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } rx_state_t;

    function automatic logic [7:0] id_char(input logic [3:0] idx);
        if (idx < 4'(ID_LEN)) begin
            return ID_CHARS[idx];
        end
        return 8'h00;
    endfunction

endpackage

// File: rtl/uart_recv.sv
// Bit-level UART receiver: 2-flop synchroniser, mid-bit sampling, 8N1 frames
// (8E1 when UART_RX_PARITY_EN is defined). Emits one-cycle valid / frame_err pulses.
`timescale 1ns/1ps
module uart_recv
    import id_rx_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int HALF_DIV = (BAUD_DIV / 2 > 0) ? BAUD_DIV / 2 : 1;
    localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_DIV - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_vld_reg;
    logic                   prev_reg;
    logic                   rx_line;
    logic                   line_fall;
    logic                   stop_good;

    rx_state_t              state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [2:0]             bit_cnt_reg;
    logic [7:0]             shift_reg;
    logic [7:0]             data_reg;
    logic                   valid_reg;
    logic                   frame_err_reg;
`ifdef UART_RX_PARITY_EN
    logic                   par_err_reg;
`endif

    // sync_vld_reg marks which synchroniser stages hold a real line sample
    // rather than their reset value, so a line held low out of reset never
    // looks like a start edge until it has been seen high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg     <= '1;
            sync_vld_reg <= '0;
            prev_reg     <= 1'b0;
        end else begin
            sync_reg     <= {sync_reg[SYNC_STAGES-2:0], din};
            sync_vld_reg <= {sync_vld_reg[SYNC_STAGES-2:0], 1'b1};
            prev_reg     <= sync_reg[SYNC_STAGES-1] & sync_vld_reg[SYNC_STAGES-1];
        end
    end

    assign rx_line   = sync_reg[SYNC_STAGES-1];
    assign line_fall = prev_reg & ~rx_line;

`ifdef UART_RX_PARITY_EN
    assign stop_good = rx_line & ~par_err_reg;
`else
    assign stop_good = rx_line;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            data_reg      <= 8'h00;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_reg   <= 1'b0;
`endif
        end else begin
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    cnt_reg     <= '0;
                    bit_cnt_reg <= '0;
                    if (line_fall) begin
                        state_reg <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_reg == CNT_HALF) begin
                        cnt_reg   <= '0;
                        // a line back high at mid start bit was only a glitch
                        state_reg <= rx_line ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt_reg == CNT_FULL) begin
                        cnt_reg     <= '0;
                        shift_reg   <= {rx_line, shift_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_reg <= ST_PARITY;
`else
                            state_reg <= ST_STOP;
`endif
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt_reg == CNT_FULL) begin
                        cnt_reg     <= '0;
                        par_err_reg <= (^shift_reg) ^ rx_line;
                        state_reg   <= ST_STOP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt_reg == CNT_FULL) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_IDLE;
                        if (stop_good) begin
                            data_reg  <= shift_reg;
                            valid_reg <= 1'b1;
                        end else begin
                            frame_err_reg <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign data      = data_reg;
    assign valid     = valid_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: rtl/id_receiver.sv
// UART receiver plus a matcher that tracks progress through the ID "2024311668".
// Frame format is 8N1, or 8E1 when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module id_receiver
    import id_rx_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic [3:0] id_idx,
    output logic       id_ok
);

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic [3:0] id_idx_reg;
    logic       id_ok_reg;

    uart_recv #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_recv (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .data      (rx_data),
        .valid     (rx_valid),
        .frame_err (rx_frame_err)
    );

    // Matcher updates the cycle after each valid byte, so id_ok always
    // follows the valid of the final ID character.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_idx_reg <= 4'd0;
            id_ok_reg  <= 1'b0;
        end else begin
            id_ok_reg <= 1'b0;
            if (rx_frame_err) begin
                id_idx_reg <= 4'd0;
            end else if (rx_valid) begin
                if (rx_data == id_char(id_idx_reg)) begin
                    if (id_idx_reg == 4'(ID_LEN - 1)) begin
                        id_idx_reg <= 4'd0;
                        id_ok_reg  <= 1'b1;
                    end else begin
                        id_idx_reg <= id_idx_reg + 4'd1;
                    end
                end else begin
                    // a mismatching byte may itself start a new ID attempt
                    id_idx_reg <= (rx_data == id_char(4'd0)) ? 4'd1 : 4'd0;
                end
            end
        end
    end

    assign data      = rx_data;
    assign valid     = rx_valid;
    assign frame_err = rx_frame_err;
    assign id_idx    = id_idx_reg;
    assign id_ok     = id_ok_reg;

endmodule
